// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Optional build macro: SERIAL_ADD_SUB_EN (adds two's-complement subtraction).
package serial_adder_ctrl_pkg;

    // Default operand/result width in bits (legal range 2..32)
    localparam int unsigned DEFAULT_WIDTH = 8;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_adder_ctrl_bit_fa.sv
// Single-bit full-adder cell: sum bit plus generate/propagate terms.
module bit_fa (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic g,
    output logic p
);

    // Sum, generate and propagate for one bit position
    assign s = a ^ b ^ c;
    assign g = a & b;
    assign p = a | b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one bit per cycle, LSB first, through one
// full-adder cell. Optional build macro: SERIAL_ADD_SUB_EN enables a - b
// when sub is captured high at start.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   s_sr;
    logic               carry;

    logic               fa_s;
    logic               fa_g;
    logic               fa_p;
    logic               carry_nxt_c;
    logic [WIDTH-1:0]   sum_fill_c;
    logic [WIDTH-1:0]   b_load_c;
    logic               c_load_c;

    // The one full-adder cell, fed from the low bits of the operand shifters
    bit_fa u_fa (
        .a (a_sr[0]),
        .b (b_sr[0]),
        .c (carry),
        .s (fa_s),
        .g (fa_g),
        .p (fa_p)
    );

    // Carry chain step and MSB-first fill of the result shifter
    assign carry_nxt_c = fa_g | (fa_p & carry);
    assign sum_fill_c  = {fa_s, s_sr[WIDTH-1:1]};

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction loads ~b with a forced carry-in of 1
    assign b_load_c = sub ? ~b : b;
    assign c_load_c = sub ? 1'b1 : c_in;
`else
    // Add-only build: sub has no path into the datapath
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load_c   = b;
    assign c_load_c   = c_in;
`endif

    // Controller FSM, datapath shifters and registered result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b_load_c;
                        s_sr  <= '0;
                        carry <= c_load_c;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    s_sr  <= sum_fill_c;
                    carry <= carry_nxt_c;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // carry holds the carry into the MSB on this last step
                        sum   <= sum_fill_c;
                        c_out <= carry_nxt_c;
                        ovf   <= carry ^ carry_nxt_c;
                        zero  <= (sum_fill_c == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_adder_ctrl;

    localparam int unsigned W  = 8;
    localparam int unsigned RW = W + 3;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .zero  (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected {ovf, c_out, zero, sum} from plain integer arithmetic
    function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic ci, input logic sb);
        logic [W-1:0] yy;
        logic         c0;
        logic [W:0]   full;
        logic         ov;
        logic         sb_unused;
        yy = y;
        c0 = ci;
        sb_unused = sb;
`ifdef SERIAL_ADD_SUB_EN
        if (sb) begin
            yy = ~y;
            c0 = 1'b1;
        end
`endif
        full = {1'b0, x} + {1'b0, yy} + (W+1)'(c0);
        ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return {ov, full[W], (full[W-1:0] == '0), full[W-1:0]};
    endfunction

    function automatic logic [RW-1:0] observed();
        return {ovf, c_out, zero, sum};
    endfunction

    // Present operands with start for one cycle; returns at the negedge after acceptance
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic sb);
        a = x; b = y; c_in = ci; sub = sb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    endtask

    // Wait for done with a bound, scrambling operand inputs each cycle
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!done && lat < int'(2*W + 4)) begin
            if (busy) bcnt++;
            @(negedge clk);
            lat++;
            a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 8'hAA; b = 8'h55; c_in = 1'b1; sub = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, c_out, ovf, zero, sum} !== {5'b00001, 8'h00}) begin
            errors++;
            $display("FAIL reset_values got busy=%b done=%b c_out=%b ovf=%b zero=%b sum=%h exp 0 0 0 0 1 00",
                     busy, done, c_out, ovf, zero, sum);
        end
        rst = 1'b0; start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_ignored got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        start_op(8'h0F, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W)) begin
            errors++;
            $display("FAIL basic_latency got %0d exp %0d", lat, W);
        end
        checks++;
        if (bc != int'(W)) begin
            errors++;
            $display("FAIL basic_busy_cycles got %0d exp %0d", bc, W);
        end
        checks++;
        if (observed() !== {1'b0, 1'b0, 1'b0, 8'h10}) begin
            errors++;
            $display("FAIL basic_result got %h exp %h", observed(), {1'b0, 1'b0, 1'b0, 8'h10});
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum !== 8'h10) begin
            errors++;
            $display("FAIL basic_after_done got done=%b busy=%b sum=%h exp 0 0 10", done, busy, sum);
        end
    endtask

    task automatic test_carry_ovf();
        int lat, bc;
        start_op(8'hFF, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W) || observed() !== {1'b0, 1'b1, 1'b1, 8'h00}) begin
            errors++;
            $display("FAIL carry_wrap got lat=%0d res=%h exp lat=%0d res=%h",
                     lat, observed(), W, {1'b0, 1'b1, 1'b1, 8'h00});
        end
        @(negedge clk);
        start_op(8'h7F, 8'h01, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W) || observed() !== {1'b1, 1'b0, 1'b0, 8'h80}) begin
            errors++;
            $display("FAIL signed_ovf got lat=%0d res=%h exp lat=%0d res=%h",
                     lat, observed(), W, {1'b1, 1'b0, 1'b0, 8'h80});
        end
        @(negedge clk);
    endtask

    task automatic test_start_during_run();
        int nd;
        logic [RW-1:0] got;
        logic [RW-1:0] exp;
        nd  = 0;
        got = '0;
        exp = model(8'h3C, 8'h55, 1'b1, 1'b0);
        start_op(8'h3C, 8'h55, 1'b1, 1'b0);
        for (int k = 1; k <= int'(W) + 6; k++) begin
            if (k == 3) begin
                a = 8'hAA; b = 8'h11; c_in = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                nd++;
                got = observed();
            end
        end
        checks++;
        if (nd != 1) begin
            errors++;
            $display("FAIL run_start_done_count got %0d exp 1", nd);
        end
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL run_start_result got %h exp %h", got, exp);
        end
    endtask

    task automatic test_reset_during_run();
        int nd, lat, bc;
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, c_out, ovf, zero, sum} !== {5'b00001, 8'h00}) begin
            errors++;
            $display("FAIL abort_values got busy=%b done=%b c_out=%b ovf=%b zero=%b sum=%h exp 0 0 0 0 1 00",
                     busy, done, c_out, ovf, zero, sum);
        end
        nd = 0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses exp 0", nd);
        end
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W) || observed() !== model(8'h12, 8'h34, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL abort_restart got lat=%0d res=%h exp lat=%0d res=%h",
                     lat, observed(), W, model(8'h12, 8'h34, 1'b0, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat1, lat2, bc;
        start_op(8'hC8, 8'h64, 1'b0, 1'b0);
        wait_done(lat1, bc);
        checks++;
        if (lat1 != int'(W) || observed() !== model(8'hC8, 8'h64, 1'b0, 1'b0)) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d res=%h exp lat=%0d res=%h",
                     lat1, observed(), W, model(8'hC8, 8'h64, 1'b0, 1'b0));
        end
        start_op(8'h21, 8'h43, 1'b1, 1'b0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap got busy=%b done=%b exp 1 0", busy, done);
        end
        wait_done(lat2, bc);
        checks++;
        if (lat2 + 1 != int'(W) + 1) begin
            errors++;
            $display("FAIL b2b_done_spacing got %0d exp %0d", lat2 + 1, W + 1);
        end
        checks++;
        if (observed() !== model(8'h21, 8'h43, 1'b1, 1'b0)) begin
            errors++;
            $display("FAIL b2b_second got %h exp %h", observed(), model(8'h21, 8'h43, 1'b1, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] xs[5] = '{8'h00, 8'h80, 8'hFF, 8'h01, 8'h7F};
        logic [W-1:0] ys[5] = '{8'h00, 8'h80, 8'hFF, 8'hFF, 8'h7F};
        logic         cs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] x, y;
        logic         ci, sb;
        logic [RW-1:0] exp;
        int lat, bc;
        for (int i = 0; i < 30; i++) begin
            if (i < 5) begin
                x = xs[i]; y = ys[i]; ci = cs[i]; sb = 1'b0;
            end else begin
                x = W'($urandom); y = W'($urandom); ci = 1'($urandom); sb = 1'($urandom);
            end
            exp = model(x, y, ci, sb);
            start_op(x, y, ci, sb);
            wait_done(lat, bc);
            checks++;
            if (lat != int'(W) || observed() !== exp) begin
                errors++;
                $display("FAIL random_%0d a=%h b=%h ci=%b sub=%b got lat=%0d res=%h exp lat=%0d res=%h",
                         i, x, y, ci, sb, lat, observed(), W, exp);
            end
            if ($urandom_range(1, 0) == 0) repeat ($urandom_range(2, 1)) @(negedge clk);
        end
        @(negedge clk);
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_sub();
        int lat, bc;
        start_op(8'h05, 8'h07, 1'b0, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W) || sum !== 8'hFE || c_out !== 1'b0) begin
            errors++;
            $display("FAIL sub_borrow got lat=%0d sum=%h c_out=%b exp lat=%0d sum=fe c_out=0",
                     lat, sum, c_out, W);
        end
        @(negedge clk);
        start_op(8'h07, 8'h05, 1'b1, 1'b1);
        wait_done(lat, bc);
        checks++;
        if (lat != int'(W) || sum !== 8'h02 || c_out !== 1'b1) begin
            errors++;
            $display("FAIL sub_no_borrow got lat=%0d sum=%h c_out=%b exp lat=%0d sum=02 c_out=1",
                     lat, sum, c_out, W);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        test_reset();
        test_basic();
        test_carry_ovf();
        test_start_during_run();
        test_reset_during_run();
        test_back_to_back();
        test_random();
`ifdef SERIAL_ADD_SUB_EN
        test_sub();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE or DONE.
REQ-005 SHALL have port a  input  WIDTH  operand A, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  operand B, captured on accepted start.
REQ-007 SHALL have port c_in  input  1  carry-in, captured on accepted start.
REQ-008 SHALL have port sub  input  1  subtract request, captured on accepted start; ignored when SERIAL_ADD_SUB_EN is undefined.
REQ-009 SHALL have port busy  output  1  high while an operation is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 SHALL have port sum  output  WIDTH  result, held stable from done until the next accepted start.
REQ-012 SHALL have port c_out  output  1  carry out of the MSB.
REQ-013 SHALL have port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.
REQ-014 SHALL have port zero  output  1  high when sum equals 0.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-016 IDLE: on start=1, SHALL capture a, b and c_in into shift/carry registers, clear the bit counter, and go to RUN; otherwise SHALL stay in IDLE.
REQ-017 RUN: each cycle SHALL process one bit, LSB first, through a single 1-bit full-adder cell: sum_bit = a^b^c; generate G = a&b; propagate P = a|b; next carry = G | (P & c).
REQ-018 RUN: SHALL shift the result bit into the sum register MSB-first-fill and increment the counter; after the cycle processing bit WIDTH-1, SHALL go to DONE.
REQ-019 Latency: start accepted at edge T SHALL give done=1 during the cycle after edge T+WIDTH, i.e. WIDTH+1 cycles from start.
REQ-020 On entering DONE, SHALL update sum, c_out, ovf and zero together and assert done for exactly one cycle; DONE then falls to IDLE next cycle unless start=1.
REQ-021 start=1 in DONE SHALL be accepted exactly as in IDLE, giving back-to-back operations with no idle gap.
REQ-022 busy SHALL be 1 in RUN only; start while busy=1 SHALL be ignored with no effect on operands or outputs.
REQ-023 Operand inputs SHALL NOT affect an operation after capture.
REQ-024 Carry/overflow width rule: ovf SHALL use the carry into bit WIDTH-1, registered on the last RUN cycle.

Reset
REQ-025 rst=1 SHALL, at the next rising edge, force IDLE and clear counter, shift registers, sum, c_out, ovf and done to 0, and set zero to 1.
REQ-026 rst asserted during RUN SHALL abort the operation without a done pulse; outputs SHALL read the reset values.
REQ-027 start coincident with rst SHALL be ignored.

Configuration
REQ-028 Macro SERIAL_ADD_SUB_EN defined: sub=1 captured on start SHALL invert captured b and force the initial carry to 1, giving a - b (c_in ignored); c_out=1 means no borrow.
REQ-029 Macro SERIAL_ADD_SUB_EN undefined: sub SHALL be ignored and the block SHALL only add; no inversion logic SHALL be synthesized.

Structure
REQ-030 Shared package/header SHALL hold the FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-031 The 1-bit full-adder cell SHALL be a separate sub-module, bit_fa (inputs a, b, c; outputs s, g, p), instantiated once.
REQ-032 The counter SHALL be sized to clog2(WIDTH) + 1 bits.

Verification (WIDTH=8)
REQ-033 a=0x0F, b=0x01, c_in=0, start pulse -> done exactly 9 cycles later, sum=0x10, c_out=0, ovf=0, zero=0; busy high for 8 cycles.
REQ-034 a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1, ovf=0, zero=1; then a=0x7F, b=0x01 -> sum=0x80, c_out=0, ovf=1.
REQ-035 Start pulse during RUN with different operands -> ignored; first result unchanged; done pulses once.
REQ-036 rst asserted in the 4th RUN cycle -> no done pulse; next cycle state IDLE, sum=0, zero=1; a new start runs normally.
REQ-037 start held in DONE with new operands -> second operation begins with no idle cycle; second done 9 cycles after the first.
REQ-038 With SERIAL_ADD_SUB_EN: a=0x05, b=0x07, sub=1 -> sum=0xFE, c_out=0; a=0x07, b=0x05, sub=1 -> sum=0x02, c_out=1.
